// File: rtl/ifetch_queue_pkg.sv
// Shared pipeline definitions for the instruction-fetch front end.
//   INSTR_W / ADDR_W / PC_STEP : instruction width, address width, sequential PC increment
//   fetch_entry_t              : one queued instruction together with its fetch address
//   fetch_state_e              : whether a memory response is due in the current cycle
//   align_pc()                 : forces a redirect address onto a 4-byte boundary
package ifetch_queue_pkg;

  localparam int unsigned INSTR_W = 32;
  localparam int unsigned ADDR_W  = 64;
  localparam int unsigned PC_STEP = 4;
  localparam int unsigned ENTRY_W = ADDR_W + INSTR_W;

  typedef struct packed {
    logic [ADDR_W-1:0]  pc;
    logic [INSTR_W-1:0] instr;
  } fetch_entry_t;

  typedef enum logic {
    FETCH_IDLE = 1'b0,
    FETCH_WAIT = 1'b1
  } fetch_state_e;

  function automatic logic [ADDR_W-1:0] align_pc(input logic [ADDR_W-1:0] addr);
    return {addr[ADDR_W-1:2], 2'b00};
  endfunction

endpackage

// File: rtl/ifetch_queue_fetch_fifo.sv
// fetch_fifo: synchronous FIFO holding fetched {pc, instr} entries.
//   clk, reset : clock and synchronous active-high reset
//   flush      : drops every entry (takes priority over push/pop)
//   push/wdata : write one entry at the tail (ignored when full)
//   pop        : retire the head entry (ignored when empty)
//   rdata      : head entry, all zeros while empty
//   full/empty : occupancy flags; count : number of valid entries
module fetch_fifo
  import ifetch_queue_pkg::*;
#(
  parameter int unsigned WIDTH = ENTRY_W,
  parameter int unsigned DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     flush,
  input  logic                     push,
  input  logic                     pop,
  input  logic [WIDTH-1:0]         wdata,
  output logic [WIDTH-1:0]         rdata,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int unsigned AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wptr;
  logic [AW-1:0]    rptr;
  logic             do_push;
  logic             do_pop;

  assign full    = (count == (AW+1)'(DEPTH));
  assign empty   = (count == '0);
  assign do_push = push & ~full;
  assign do_pop  = pop & ~empty;
  assign rdata   = empty ? '0 : mem[rptr];

  // DEPTH is a power of two, so the pointers wrap naturally at AW bits.
  always_ff @(posedge clk) begin
    if (reset || flush) begin
      wptr  <= '0;
      rptr  <= '0;
      count <= '0;
    end else begin
      if (do_push) wptr <= wptr + AW'(1);
      if (do_pop)  rptr <= rptr + AW'(1);
      case ({do_push, do_pop})
        2'b10:   count <= count + (AW+1)'(1);
        2'b01:   count <= count - (AW+1)'(1);
        default: count <= count;
      endcase
    end
  end

  // Storage needs no reset: entries are only visible through count.
  always_ff @(posedge clk) begin
    if (do_push && !flush && !reset) mem[wptr] <= wdata;
  end

endmodule

// File: rtl/ifetch_queue.sv
// ifetch_queue: sequential instruction fetcher feeding a small decode queue.
//   clk, reset        : clock and synchronous active-high reset
//   imem_req/addr     : fetch request and byte address to instruction memory
//   imem_rdata        : instruction word, returned one cycle after its request
//   branch_taken/target : redirect strobe and new fetch address; flushes the queue
//   out_valid/ready   : head handshake towards decode
//   out_instr/out_pc  : head instruction and its address (zero when empty)
// Parameters: PC_RESET (first fetch address), DEPTH (queue entries, power of two 2..8).
module ifetch_queue
  import ifetch_queue_pkg::*;
#(
  parameter logic [ADDR_W-1:0] PC_RESET = 64'h0000_0000_0000_0000,
  parameter int unsigned       DEPTH    = 4
) (
  input  logic               clk,
  input  logic               reset,
  output logic               imem_req,
  output logic [ADDR_W-1:0]  imem_addr,
  input  logic [INSTR_W-1:0] imem_rdata,
  input  logic               branch_taken,
  input  logic [ADDR_W-1:0]  branch_target,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [INSTR_W-1:0] out_instr,
  output logic [ADDR_W-1:0]  out_pc
);

  // Wide enough for count + inflight and DEPTH + pop without overflow.
  localparam int unsigned CW = $clog2(DEPTH) + 2;

  fetch_state_e            state_q, state_d;
  logic [ADDR_W-1:0]       pc_q, pc_d;
  logic [ADDR_W-1:0]       req_pc_q;

  logic                    fifo_full;
  logic                    fifo_empty;
  logic [$clog2(DEPTH):0]  fifo_count;
  fetch_entry_t            push_entry;
  fetch_entry_t            head_entry;

  logic                    push;
  logic                    pop;
  logic                    flush;
  logic [CW-1:0]           occupancy;
  logic [CW-1:0]           limit;

  fetch_fifo #(
    .WIDTH (ENTRY_W),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk   (clk),
    .reset (reset),
    .flush (flush),
    .push  (push),
    .pop   (pop),
    .wdata (push_entry),
    .rdata (head_entry),
    .full  (fifo_full),
    .empty (fifo_empty),
    .count (fifo_count)
  );

  assign imem_addr = pc_q;
  assign out_valid = ~reset & ~fifo_empty;
  assign out_instr = out_valid ? head_entry.instr : '0;
  assign out_pc    = out_valid ? head_entry.pc    : '0;
  assign pop       = out_valid & out_ready;
  assign flush     = branch_taken;

  // The response always lands exactly one cycle after the request, so the
  // entry is formed from the address latched at request time.
  assign push_entry.pc    = req_pc_q;
  assign push_entry.instr = imem_rdata;

  // A redirect in the response cycle discards the response.
  assign push = (state_q == FETCH_WAIT) & ~branch_taken & ~reset & ~fifo_full;

  // Request only if the reply is guaranteed a slot: entries held plus the
  // one still in flight, less the one leaving this cycle, must stay below DEPTH.
  always_comb begin
    occupancy = CW'(fifo_count) + CW'(state_q == FETCH_WAIT);
    limit     = CW'(DEPTH) + CW'(pop);
    imem_req  = ~reset & ~branch_taken & (occupancy < limit);
  end

  always_comb begin
    state_d = imem_req ? FETCH_WAIT : FETCH_IDLE;
    pc_d    = pc_q;
    if (branch_taken) begin
      pc_d = align_pc(branch_target);
    end else if (imem_req) begin
      pc_d = pc_q + ADDR_W'(PC_STEP);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= FETCH_IDLE;
      pc_q     <= PC_RESET;
      req_pc_q <= '0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      if (imem_req) req_pc_q <= pc_q;
    end
  end

endmodule
